seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Receive-side counterpart of the team's hex-to-7-segment encoder. It watches a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and reconstructs the hex value shown on each digit. Each pattern must be stable for a programmable settle time before it is captured. It sits on the display pins in self-checking top levels and in the lab capture harness, so display-driving designs can be verified on-chip.

## Interface
- NDIG, 4: number of multiplexed digits, 1..8.
- SETTLE, 4: consecutive stable cycles required before capture, 1..255.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- seg_n  in  7  segment lines, active-low, bit order gfedcba (bit 0 = a).
- an_n  in  NDIG  anode selects, active-low; bit i selects digit i.
- digits  out  4*NDIG  captured nibble of digit i at [4i+3:4i].
- dig_ok  out  NDIG  bit i = last capture of digit i was a legal hex glyph.
- blank  out  NDIG  bit i = last capture of digit i was all segments off.
- upd  out  1  one-cycle pulse when a capture writes a digit.
- upd_idx  out  3  index of the digit written; valid while upd=1.
- err_multi  out  1  high each cycle the registered an_n has more than one active bit.

## Operation
- Input stage: seg_n and an_n are registered once (s_seg, s_an), with s_prev holding the previous s_seg/s_an. A change is s_seg/s_an != s_prev.
- one_hot: exactly one zero bit in s_an. idx: position of that bit.
- FSM states are IDLE, SETTLE and HELD, with an 8-bit counter cnt.
  - IDLE: if one_hot, go to SETTLE with cnt=1. Otherwise stay.
  - SETTLE:
    - On a change: if one_hot, restart with cnt=1; otherwise go to IDLE.
    - With no change: cnt increments.
    - When cnt==SETTLE: capture into digit idx, pulse upd, go to HELD.
  - HELD: on a change, behave as SETTLE does on a change. With no change, stay and never recapture.
- A segment change while HELD on the same anode is re-settled and recaptured, because the displayed content has changed.
- Glyph decode of s_seg:
  - Legal glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Legal glyph: nibble = value, dig_ok=1, blank=0.
  - 1111111: nibble=0, dig_ok=0, blank=1.
  - Any other pattern: nibble=0, dig_ok=0, blank=0.
- A capture updates only the fields of digit idx. All other digits hold.
- More than one active anode: err_multi is high, there is no capture, and the FSM goes to IDLE. All anodes inactive: IDLE, with err_multi low.

## Timing
- Reset values: digits=0, dig_ok=0, blank=0, upd=0, upd_idx=0, err_multi=0. FSM is IDLE, cnt=0, and s_seg/s_an/s_prev are all ones (inactive).
- Capture latency: edge t is the first to register a new stable seg_n/an_n.
  - FSM enters SETTLE (cnt=1) at edge t+1.
  - Capture happens at edge t+SETTLE.
  - upd, upd_idx and the new digit fields are visible in the cycle after edge t+SETTLE.
- Any change before the capture edge aborts the capture. Nothing is written.
- err_multi is registered off s_an, so it lags an_n by 2 edges.
- Reset mid-settle discards the partial count. Reset on a capture edge wins, so no write and no upd occur.
- When SETTLE=1, capture occurs at edge t+1 (the SETTLE entry edge).

## Structure
- Package seg7_pkg holds:
  - the 16 glyph constants and SEG_BLANK=7'b1111111;
  - the FSM state enum (IDLE, SETTLE, HELD).
- Sub-module seg7_glyph_lut is combinational: 7-bit pattern in; nibble, ok and blank out. It is shared with future display checkers.
- Top level contains the input registers, change detector, one-hot/index logic, FSM/counter and per-digit capture registers.

## Test plan
- Reset release:
  - Stimulus: an_n=1111, seg_n=1111111 for 20 cycles.
  - Required: all outputs stay at reset values; upd never pulses.
- Single capture, SETTLE=4:
  - Stimulus: an_n=1101, seg_n=0100100 held.
  - Required: one upd with upd_idx=1, digits[7:4]=2, dig_ok[1]=1, exactly 4 edges after first registration; no further upd while held.
- Full scan:
  - Stimulus: cycle digits 0..3 through glyphs A, b, C, F, 8 cycles each.
  - Required: digits=16'hFCBA, dig_ok=1111.
- Glitch abort:
  - Stimulus: on digit 0, seg_n toggles after 2 stable cycles, then holds 0010010.
  - Required: exactly one upd, after re-settle; digits[3:0]=5.
- Illegal, blank and multi-anode patterns:
  - Stimulus 1: seg_n=0111111 on digit 2. Required: dig_ok[2]=0, blank[2]=0, nibble 0.
  - Stimulus 2: seg_n=1111111 on digit 2. Required: blank[2]=1.
  - Stimulus 3: an_n=0011. Required: err_multi high; no upd.
- Reset mid-settle:
  - Stimulus: rst_n low at cnt=3.
  - Required: no capture; after release, a full SETTLE is needed again.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants and FSM states shared by the 7-segment scan decoder
package seg7_pkg;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] GLYPH_0   = 7'b1000000;
    localparam logic [6:0] GLYPH_1   = 7'b1111001;
    localparam logic [6:0] GLYPH_2   = 7'b0100100;
    localparam logic [6:0] GLYPH_3   = 7'b0110000;
    localparam logic [6:0] GLYPH_4   = 7'b0011001;
    localparam logic [6:0] GLYPH_5   = 7'b0010010;
    localparam logic [6:0] GLYPH_6   = 7'b0000010;
    localparam logic [6:0] GLYPH_7   = 7'b1111000;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0010000;
    localparam logic [6:0] GLYPH_A   = 7'b0001000;
    localparam logic [6:0] GLYPH_B   = 7'b0000011;
    localparam logic [6:0] GLYPH_C   = 7'b1000110;
    localparam logic [6:0] GLYPH_D   = 7'b0100001;
    localparam logic [6:0] GLYPH_E   = 7'b0000110;
    localparam logic [6:0] GLYPH_F   = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HELD
    } state_t;

endpackage

// File: rtl/seg7_glyph_lut.sv
// rtl/seg7_glyph_lut.sv - combinational active-low 7-segment pattern to hex nibble decoder
module seg7_glyph_lut
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       ok,
    output logic       blank
);

    always_comb begin
        nibble = 4'h0;
        ok     = 1'b1;
        blank  = 1'b0;
        case (seg)
            GLYPH_0:   nibble = 4'h0;
            GLYPH_1:   nibble = 4'h1;
            GLYPH_2:   nibble = 4'h2;
            GLYPH_3:   nibble = 4'h3;
            GLYPH_4:   nibble = 4'h4;
            GLYPH_5:   nibble = 4'h5;
            GLYPH_6:   nibble = 4'h6;
            GLYPH_7:   nibble = 4'h7;
            GLYPH_8:   nibble = 4'h8;
            GLYPH_9:   nibble = 4'h9;
            GLYPH_A:   nibble = 4'hA;
            GLYPH_B:   nibble = 4'hB;
            GLYPH_C:   nibble = 4'hC;
            GLYPH_D:   nibble = 4'hD;
            GLYPH_E:   nibble = 4'hE;
            GLYPH_F:   nibble = 4'hF;
            SEG_BLANK: begin
                ok    = 1'b0;
                blank = 1'b1;
            end
            default:   ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - reconstructs per-digit hex values from a multiplexed active-low 7-segment bus
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [NDIG-1:0]       an_n,
    output logic [4*NDIG-1:0]     digits,
    output logic [NDIG-1:0]       dig_ok,
    output logic [NDIG-1:0]       blank,
    output logic                  upd,
    output logic [2:0]            upd_idx,
    output logic                  err_multi
);

    localparam logic [7:0] SETTLE_C = SETTLE[7:0];

    logic [6:0]      s_seg, p_seg;
    logic [NDIG-1:0] s_an, p_an;
    logic            change;
    logic [3:0]      nzero;
    logic [2:0]      idx;
    logic            one_hot, multi;
    state_t          state, state_n;
    logic [7:0]      cnt, cnt_n;
    logic            capture;
    logic [3:0]      lut_nib;
    logic            lut_ok, lut_blank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg <= '1;
            s_an  <= '1;
            p_seg <= '1;
            p_an  <= '1;
        end else begin
            s_seg <= seg_n;
            s_an  <= an_n;
            p_seg <= s_seg;
            p_an  <= s_an;
        end
    end

    assign change = (s_seg != p_seg) || (s_an != p_an);

    always_comb begin
        nzero = 4'd0;
        idx   = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (!s_an[i]) begin
                nzero = nzero + 4'd1;
                idx   = i[2:0];
            end
        end
    end

    assign one_hot = (nzero == 4'd1);
    assign multi   = (nzero > 4'd1);

    seg7_glyph_lut u_lut (
        .seg    (s_seg),
        .nibble (lut_nib),
        .ok     (lut_ok),
        .blank  (lut_blank)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (one_hot) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 8'd1;
                end
            end
            ST_SETTLE, ST_HELD: begin
                if (change) begin
                    if (one_hot) begin
                        state_n = ST_SETTLE;
                        cnt_n   = 8'd1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = 8'd0;
                    end
                end else if (state == ST_SETTLE) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 8'd0;
            end
        endcase
        // Checking the next count also covers SETTLE=1, where entry and capture coincide
        if (state_n == ST_SETTLE && cnt_n == SETTLE_C) begin
            capture = 1'b1;
            state_n = ST_HELD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits    <= '0;
            dig_ok    <= '0;
            blank     <= '0;
            upd       <= 1'b0;
            upd_idx   <= 3'd0;
            err_multi <= 1'b0;
        end else begin
            upd       <= capture;
            err_multi <= multi;
            if (capture) begin
                upd_idx <= idx;
                for (int i = 0; i < NDIG; i++) begin
                    if (idx == i[2:0]) begin
                        digits[4*i +: 4] <= lut_nib;
                        dig_ok[i]        <= lut_ok;
                        blank[i]         <= lut_blank;
                    end
                end
            end
        end
    end

endmodule
